// File: rtl/mmio_lsu_pkg.sv
// mmio_lsu_pkg: op encodings, FSM states and the decode/lane helpers
// shared by the load/store unit.
package mmio_lsu_pkg;
   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LW  = 3'b010;
   localparam logic [2:0] OP_LBU = 3'b011;
   localparam logic [2:0] OP_LHU = 3'b100;
   localparam logic [2:0] OP_SB  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;
   localparam logic [2:0] OP_SW  = 3'b111;

   typedef enum logic [1:0] {IDLE, RAMRD, RESP} state_t;
   typedef enum logic [1:0] {RG_RAM, RG_IN, RG_OUT} region_t;

   function automatic region_t region_of(input logic hi, input logic mid);
      return hi ? RG_OUT : (mid ? RG_IN : RG_RAM);
   endfunction

   function automatic logic is_store(input logic [2:0] op);
      return op >= OP_SB;
   endfunction

   function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
      return ((op == OP_LH || op == OP_LHU || op == OP_SH) && a[0]) ||
             ((op == OP_LW || op == OP_SW) && a != 2'b00);
   endfunction

   function automatic logic [3:0] byte_en(input logic [2:0] op, input logic [1:0] a);
      return op == OP_SW ? 4'hF : op == OP_SH ? (a[1] ? 4'hC : 4'h3) :
             op == OP_SB ? 4'b0001 << a : 4'h0;
   endfunction

   // Replicate the low byte/half across the word so any enabled lane sees it.
   function automatic logic [31:0] align_wdata(input logic [2:0] op, input logic [31:0] d);
      return op == OP_SB ? {4{d[7:0]}} : op == OP_SH ? {2{d[15:0]}} : d;
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] a,
                                            input logic [31:0] w);
      logic [7:0] b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      return op == OP_LB ? {{24{b[7]}}, b} : op == OP_LBU ? {24'h0, b} :
             op == OP_LH ? {{16{h[15]}}, h} : op == OP_LHU ? {16'h0, h} : w;
   endfunction
endpackage

// File: rtl/mmio_lsu_bram.sv
// bram_be: DEPTHx32 single-port RAM with byte-enable write and registered read.
module bram_be #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [3:0]               we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (en) begin
         for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         if (we == 4'h0) rdata <= mem[addr];
      end
endmodule

// File: rtl/mmio_lsu.sv
// mmio_lsu: load/store unit decoding byte addresses into word RAM,
// a synchronised input port and a byte-writable output register.
module mmio_lsu import mmio_lsu_pkg::*; #(
   parameter int ADDR_W      = 8,
   parameter int N_IN        = 4,
   parameter int N_OUT       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              err,
   output logic              busy,
   input  logic [N_IN-1:0]   switch,
   output logic [N_OUT-1:0]  result
);
   localparam int DEPTH = 2 ** (ADDR_W - 4);

   state_t state, state_n;
   region_t rg;
   logic [SYNC_STAGES-1:0][N_IN-1:0] sync;
   logic [2:0]  op_q;
   logic [1:0]  lane_q;
   logic        mis_q, accept, mis, ram_ld;
   logic [3:0]  be;
   logic [31:0] wd, word, ram_q, res_n;

   assign accept = state == IDLE && req;
   assign rg     = region_of(addr[ADDR_W-1], addr[ADDR_W-2]);
   assign mis    = misaligned(op, addr[1:0]);
   assign be     = mis ? 4'h0 : byte_en(op, addr[1:0]);
   assign wd     = align_wdata(op, wdata);
   assign ram_ld = rg == RG_RAM && !is_store(op) && !mis;
   assign busy   = state != IDLE;

   // Stores write on the accepting edge; aligned loads issue their read there too.
   bram_be #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .en    (accept && rg == RG_RAM && !mis),
      .we    (be),
      .addr  (addr[ADDR_W-3:2]),
      .wdata (wd),
      .rdata (ram_q)
   );

   always_comb begin
      res_n = 32'(result);
      for (int i = 0; i < 4; i++)
         if (be[i]) res_n[8*i +: 8] = wd[8*i +: 8];
   end

   always_comb
      state_n = state == IDLE  ? (req ? (ram_ld ? RAMRD : RESP) : IDLE) :
                state == RAMRD ? RESP : IDLE;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state  <= IDLE;
         sync   <= '0;
         result <= '0;
         rdata  <= '0;
         ready  <= 1'b0;
         err    <= 1'b0;
         op_q   <= '0;
         lane_q <= '0;
         mis_q  <= 1'b0;
         word   <= '0;
      end else begin
         state <= state_n;
         sync  <= {sync[SYNC_STAGES-2:0], switch};
         ready <= state == RESP;
         err   <= state == RESP && mis_q;
         if (state == RESP)
            rdata <= (is_store(op_q) || mis_q) ? 32'h0 : load_ext(op_q, lane_q, word);
         if (accept) begin
            op_q   <= op;
            lane_q <= addr[1:0];
            mis_q  <= mis;
            word   <= rg == RG_OUT ? 32'(result) : 32'(sync[SYNC_STAGES-1]);
         end
         if (state == RAMRD) word <= ram_q;
         if (accept && rg == RG_OUT) result <= res_n[N_OUT-1:0];
      end
endmodule
